// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared character constants and helpers for the UART transmit path
//
// Purpose: line-ending characters used by the transmit FIFO and the command
// handler, plus the output-register source selector type.

package uart_tx_fifo_pkg;

    localparam logic [7:0] CHAR_CR      = 8'h0D;
    localparam logic [7:0] CHAR_NEWLINE = 8'h0A;

    // Which source feeds the output register on a load.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LF   = 2'd1,
        SRC_MEM  = 2'd2
    } out_src_e;

    function automatic logic is_cr(input logic [7:0] b);
        return b == CHAR_CR;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo_mem.sv
// rtl/uart_tx_fifo_sync_fifo_mem.sv - DEPTH x 8 storage with registered pointers
//
// Purpose: byte storage array with wrap-bit pointers.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers only)
//   wr_en       write wr_data at the write pointer (ignored when full)
//   wr_data     byte to store
//   rd_en       advance the read pointer (ignored when empty)
//   rd_data     byte at the registered read pointer
//   full/empty  derived from registered pointers only
//   level       number of stored bytes, 0..DEPTH

module sync_fifo_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_wr;
    logic          do_rd;

    // Pointers carry one extra MSB so that full and empty are distinguishable
    // when the address bits match.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign level = wr_ptr_q - rd_ptr_q;

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage contents need no reset: empty pointers make them unobservable.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO in front of the UART transmitter with optional CR->CRLF expansion
//
// Purpose: buffers producer bytes, presents them one at a time through a
// registered output stage, inserts 8'h0A after each transmitted 8'h0D when
// AUTO_LF is set, and records dropped pushes in a sticky overflow flag.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_data/in_valid/in_ready producer byte handshake
//   out_data/out_valid/out_ready transmitter byte handshake
//   level                    bytes held in storage (output register excluded)
//   overflow / overflow_clr  sticky dropped-push flag and its clear

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter bit AUTO_LF = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       lf_pending_q, lf_pending_d;
    logic       overflow_q, overflow_d;

    logic       full;
    logic       empty;
    logic [7:0] head_data;
    logic       push;
    logic       pop;
    logic       out_xfer;
    logic       cr_xfer;
    logic       load_en;
    out_src_e   src;

    sync_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // in_ready comes from registered pointers only, so a pop in the same
    // cycle never opens space for a push until the following cycle.
    assign in_ready = !full;
    assign push     = in_valid && !full;

    assign out_xfer = out_valid_q && out_ready;
    assign cr_xfer  = AUTO_LF && out_xfer && is_cr(out_data_q);
    assign load_en  = !out_valid_q || out_ready;

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        lf_pending_d = lf_pending_q;
        pop          = 1'b0;
        src          = SRC_NONE;

        if (cr_xfer) begin
            // The byte after a CR must be the LF, so the storage head is not
            // loaded this cycle; the LF goes out from the pending flag on the
            // next load, leaving a one-cycle gap on out_valid.
            lf_pending_d = 1'b1;
            out_valid_d  = 1'b0;
        end else if (load_en) begin
            if (lf_pending_q) begin
                src = SRC_LF;
            end else if (!empty) begin
                src = SRC_MEM;
            end

            case (src)
                SRC_LF: begin
                    out_data_d   = CHAR_NEWLINE;
                    out_valid_d  = 1'b1;
                    lf_pending_d = 1'b0;
                end
                SRC_MEM: begin
                    out_data_d  = head_data;
                    out_valid_d = 1'b1;
                    pop         = 1'b1;
                end
                default: begin
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // A new overflow event takes precedence over a simultaneous clear.
    always_comb begin
        overflow_d = (in_valid && full) || (overflow_q && !overflow_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            lf_pending_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            lf_pending_q <= lf_pending_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo (AUTO_LF on and off)

module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       overflow_clr = 1'b0;

    logic       in_ready, out_valid, overflow;
    logic [7:0] out_data;
    logic [4:0] level;

    logic       n_in_ready, n_out_valid, n_overflow;
    logic [7:0] n_out_data;
    logic [4:0] n_level;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_n[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .AUTO_LF(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    uart_tx_fifo #(.DEPTH(DEPTH), .AUTO_LF(1'b0)) u_dut_nolf (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(n_in_ready), .out_data(n_out_data), .out_valid(n_out_valid),
        .out_ready(out_ready), .level(n_level), .overflow(n_overflow),
        .overflow_clr(overflow_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: accepted bytes are queued (plus an LF after each CR for the
    // AUTO_LF instance); every output transfer is popped and compared.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                if (in_data == 8'h0D) exp_q.push_back(8'h0A);
            end
            if (in_valid && n_in_ready) exp_n.push_back(in_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("lf_unexpected_byte", 32'(out_data), 32'h100);
                end else begin
                    e = exp_q.pop_front();
                    check_val("lf_out_byte", 32'(out_data), 32'(e));
                end
            end
            if (n_out_valid && out_ready) begin
                if (exp_n.size() == 0) begin
                    check_val("nolf_unexpected_byte", 32'(n_out_data), 32'h100);
                end else begin
                    e = exp_n.pop_front();
                    check_val("nolf_out_byte", 32'(n_out_data), 32'(e));
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check_val("push_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_data  = b;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || exp_n.size() != 0) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check_val("drain_lf_left", 32'(exp_q.size()), 32'd0);
        check_val("drain_nolf_left", 32'(exp_n.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_val("idle_out_valid", 32'(out_valid), 32'd0);
        check_val("idle_level", 32'(level), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'h00);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic transfer and latency
        out_ready = 1'b1;
        in_data = 8'h23; in_valid = 1'b1;
        @(posedge clk); #1;
        check_val("lat_not_yet", 32'(out_valid), 32'd0);
        in_data = 8'h2E;
        @(posedge clk); #1;
        check_val("lat_first_valid", 32'(out_valid), 32'd1);
        check_val("lat_first_data", 32'(out_data), 32'h23);
        in_data = 8'h23;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Fill to full, overflow and its clear
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) push(8'(i));
        check_val("full_in_ready", 32'(in_ready), 32'd0);
        check_val("full_level", 32'(level), 32'd16);
        check_val("full_head", 32'(out_data), 32'h00);
        check_val("ovf_before", 32'(overflow), 32'd0);
        in_data = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        check_val("ovf_set", 32'(overflow), 32'd1);
        in_data = 8'h12; overflow_clr = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("ovf_set_wins", 32'(overflow), 32'd1);
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        check_val("ovf_cleared", 32'(overflow), 32'd0);
        check_val("ovf_level_kept", 32'(level), 32'd16);
        drain();

        // CR expansion; level excludes the inserted LF
        out_ready = 1'b0;
        push(8'h41); push(8'h0D); push(8'h42);
        check_val("cr_level", 32'(level), 32'd2);
        drain();
        push(8'h0D); push(8'h0D); push(8'h43);
        drain();

        // Output stall then toggling ready with random bytes
        out_ready = 1'b0;
        push(8'h5A); push(8'h5B);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("stall_valid", 32'(out_valid), 32'd1);
            check_val("stall_data", 32'(out_data), 32'h5A);
        end
        fork
            begin
                for (int i = 0; i < 40; i++) push(8'($urandom_range(0, 255)));
            end
            begin
                for (int k = 0; k < 120; k++) begin
                    out_ready = ~out_ready;
                    @(posedge clk); #1;
                end
            end
        join
        drain();

        // Reset while bytes are queued and an LF is pending
        out_ready = 1'b0;
        push(8'h0D);
        for (int i = 0; i < 9; i++) push(8'h60 + 8'(i));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        exp_n.delete();
        #1;
        check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_level", 32'(level), 32'd0);
        check_val("mid_rst_overflow", 32'(overflow), 32'd0);
        check_val("mid_rst_nolf_valid", 32'(n_out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(8'h55);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
